ahb_subordinate: RTL
====================

Name: ahb_subordinate

Overview:
- AHB-Lite subordinate (responder) that gives the bus manager access to the accelerator `controller`.
- Provides a start/status register interface and a 4-entry write FIFO that feeds operand words to the controller.
- Captures the controller's result word for readback.
- Sits between the SoC AHB-Lite fabric and `controller`; it is the bus-facing end of the controller's command interface.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 32, bus and FIFO word width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- hsel  in  1  subordinate select
- haddr  in  4  byte address (0x0, 0x4, 0x8, 0xC)
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hsize  in  3  only 3'b010 (word) is legal
- hwrite  in  1  1=write
- hwdata  in  DATA_WIDTH  write data, valid in data phase
- hrdata  out  DATA_WIDTH  read data, valid in data phase
- hreadyout  out  1  0 = insert wait / first error cycle
- hresp  out  1  1 = ERROR
- start  out  1  one-cycle pulse to controller
- op_valid  out  1  FIFO head valid toward controller
- op_data  out  DATA_WIDTH  FIFO head word
- op_ready  in  1  controller pops the head when op_valid & op_ready
- busy  in  1  controller busy level
- done  in  1  controller done pulse
- result  in  DATA_WIDTH  controller result; sampled when done=1

Behaviour:
- Reset (async, n_rst=0):
  - hrdata=0, hreadyout=1, hresp=0, start=0.
  - FIFO empty, so op_valid=0 and op_data=0.
  - done_sticky=0, result register=0, error state cleared.
- Transfer acceptance: a transfer is accepted in the address phase when hsel & htrans[1] & hreadyout. On acceptance, haddr, hwrite and hsize are latched for the data phase. IDLE and BUSY transfers get an OKAY, zero-wait response.
- Register map:
  - 0x0 CTRL, write-only. Writing bit0=1 pulses start for exactly one cycle, in the cycle after the data phase. Ignored while busy=1; the transfer still completes with OKAY.
  - 0x4 STATUS, read-only. {28'b0, fifo_full, fifo_empty, done_sticky, busy}. A read clears done_sticky at the end of the data phase. A done pulse in that same cycle wins, so done_sticky stays 1.
  - 0x8 OPERAND, write-only. Pushes hwdata into the FIFO in the data phase. If the FIFO is full, hreadyout is held 0 (wait states) until a pop frees an entry. The push and hreadyout=1 then happen in that same cycle.
  - 0xC RESULT, read-only. Returns the result register, which is loaded from `result` on each done pulse.
- Read timing: hrdata is registered from the latched address at the address-phase edge and is valid throughout the data phase with zero wait states. A STATUS read returns the values as of the accepted address-phase edge.
- Errors: a write to 0x4/0xC, a read from 0x0/0x8, or hsize≠word produces a two-cycle ERROR.
  - Cycle 1: hreadyout=0, hresp=1.
  - Cycle 2: hreadyout=1, hresp=1.
  - No register or FIFO side effect.
  - A new address phase presented during cycle 2 is accepted normally.
- FIFO: circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH), so full and empty are unambiguous. Pointers wrap modulo 2·FIFO_DEPTH.
  - Simultaneous push and pop when full: the pop frees an entry, so the stalled push completes in the same cycle.
  - Simultaneous push and pop when empty: no bypass; op_valid rises the cycle after the push.
  - op_data is the combinational read of the head entry.
- Back-to-back: pipelined NONSEQ/SEQ transfers are supported. A write data phase overlapping the next address phase must not corrupt the latched address.
- FSM states:
  - IDLE
  - DATA (OKAY data phase)
  - STALL (FIFO full)
  - ERR1, ERR2 (ERROR cycles)
- FSM transitions:
  - IDLE→DATA on accept.
  - DATA→DATA on pipelined accept, else IDLE.
  - DATA→STALL when an OPERAND write sees full; STALL→DATA-complete on pop.
  - Illegal access → ERR1 → ERR2 → IDLE or DATA.
- Reset mid-transfer: all state is cleared immediately and the FIFO contents are discarded.

Test Plan:
- Reset: after n_rst low for 2 cycles → hreadyout=1, hresp=0, start=0, op_valid=0; a STATUS read returns 0x00000004 (empty=1).
- Write 0x0 with 0x1 while busy=0 → start high for exactly 1 cycle after the data phase. Repeat with busy=1 → no start pulse, response OKAY.
- Write 0x8 with 0xA1..0xA4 and op_ready=0 → STATUS returns 0x00000008 (full=1). A 5th write 0xA5 stalls. Raise op_ready for 1 cycle → 0xA1 pops, 0xA5 is accepted the same cycle. Draining then yields 0xA2, 0xA3, 0xA4, 0xA5 in order.
- Pulse done with result=0xDEADBEEF → read 0xC returns 0xDEADBEEF. Read 0x4 returns bit1=1; an immediate second read returns bit1=0.
- Write to 0xC, read from 0x8, and a byte write (hsize=0) to 0x8 → each gives the two-cycle ERROR (hreadyout 0→1, hresp=1 both cycles), with FIFO count and registers unchanged.
- Back-to-back NONSEQ write 0x8 (0x11) then read 0x4 → the read shows empty=0 and zero wait states. Assert n_rst mid data phase → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_subordinate.sv
// rtl/ahb_subordinate.sv - AHB-Lite subordinate for the accelerator controller
// Start/status registers, operand FIFO toward the controller and result capture.
module ahb_subordinate #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  hsel,
   input  logic [3:0]            haddr,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hsize,
   input  logic                  hwrite,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic                  start,
   output logic                  op_valid,
   output logic [DATA_WIDTH-1:0] op_data,
   input  logic                  op_ready,
   input  logic                  busy,
   input  logic                  done,
   input  logic [DATA_WIDTH-1:0] result
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DATA  = 3'd1;
   localparam logic [2:0] S_STALL = 3'd2;
   localparam logic [2:0] S_ERR1  = 3'd3;
   localparam logic [2:0] S_ERR2  = 3'd4;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_OPER   = 2'd2;
   localparam logic [1:0] A_RESULT = 2'd3;

   logic [2:0]            state_q, state_d;
   logic [1:0]            addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  start_q, start_d;
   logic                  sticky_q, sticky_d;
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic fifo_full, fifo_empty, full_d, empty_d;
   logic push, pop, data_phase, op_wr, stalled, accept, illegal;
   logic unused_bits;

   assign unused_bits = ^{haddr[1:0], htrans[0]};

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
   assign op_valid   = !fifo_empty;
   assign op_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign pop        = op_valid & op_ready;

   assign data_phase = (state_q == S_DATA) || (state_q == S_STALL);
   assign op_wr      = data_phase & write_q & (addr_q == A_OPER);
   // A pop in the same cycle frees the slot the stalled push is waiting on.
   assign stalled    = op_wr & fifo_full & !pop;
   assign push       = op_wr & !stalled;

   assign hreadyout  = !(stalled || (state_q == S_ERR1));
   assign hresp      = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign hrdata     = hrdata_q;
   assign start      = start_q;

   assign accept  = hsel & htrans[1] & hreadyout;
   assign illegal = (hsize != 3'b010) ||
                    ( hwrite &  haddr[2]) ||
                    (!hwrite & !haddr[2]);

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   assign empty_d  = (wr_ptr_d == rd_ptr_d);
   assign full_d   = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}});

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      hrdata_d = hrdata_q;
      result_d = done ? result : result_q;
      start_d  = data_phase & write_q & (addr_q == A_CTRL) & hwdata[0] & !busy;
      sticky_d = sticky_q;
      if (data_phase && !write_q && (addr_q == A_STATUS)) sticky_d = 1'b0;
      if (done) sticky_d = 1'b1;

      if (accept) begin
         addr_d  = haddr[3:2];
         write_d = hwrite;
         state_d = illegal ? S_ERR1 : S_DATA;
         if (!hwrite) begin
            hrdata_d = '0;
            // Status reflects this edge's FIFO/sticky updates so pipelined reads see them.
            if (!illegal && haddr[3:2] == A_STATUS)
               hrdata_d = {{(DATA_WIDTH-4){1'b0}}, full_d, empty_d, sticky_d, busy};
            else if (!illegal && haddr[3:2] == A_RESULT)
               hrdata_d = result_q;
         end
      end else begin
         case (state_q)
            S_DATA, S_STALL: state_d = stalled ? S_STALL : S_IDLE;
            S_ERR1:          state_d = S_ERR2;
            default:         state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
         result_q <= '0;
         start_q  <= 1'b0;
         sticky_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
         result_q <= result_d;
         start_q  <= start_d;
         sticky_q <= sticky_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= hwdata;
   end

endmodule
